eeprom_cfg_loader: RTL and testbench
====================================

# eeprom_cfg_loader

Boot-time configuration sequencer for the node's I2C EEPROM reader. After a power-up settle delay it requests a page read from `i2c_eeprom` and supervises the transfer with a timeout and a bounded retry count. It validates the page with a magic byte and an XOR checksum, then publishes node ID, trigger enable and status to the application top level. A host or top-level FSM can re-run the load on demand with a reload pulse.

## Interface
- `WAIT_CNT`, default 10000000: power-up settle delay in cycles (500 ms at 20 MHz).
- `TIMEOUT_CNT`, default 2000000: maximum cycles from start pulse to done.
- `MAX_RETRY`, default 3: number of extra attempts after the first failure.
- `DEV_ADDR`, default 7'h50: EEPROM device address.
- `PAGE_ADDR`, default 8'h00: configuration page.
- `RX_ID_1`, default 8'd2: first receiver node ID.
- `RX_ID_2`, default 8'd3: second receiver node ID.
- `CFG_MAGIC`, default 8'hA5: required value of page byte 1.
- `clk`  in  1: single system clock (20 MHz PLL output).
- `reset_n`  in  1: reset. Synchronous, active-low.
- `i_reload`  in  1: one-cycle request to reload configuration.
- `o_eep_start`  out  1: one-cycle read request to `i2c_eeprom`.
- `o_eep_mode`  out  1: tied 0 (read).
- `o_eep_dev_addr`  out  7: constant `DEV_ADDR`.
- `o_eep_page_addr`  out  8: constant `PAGE_ADDR`.
- `i_eep_busy`  in  1: EEPROM controller busy.
- `i_eep_done`  in  1: one-cycle pulse; page bytes are valid in this cycle.
- `i_page_b0` … `i_page_b7`  in  8 each: page bytes.
- `o_node_id`  out  8: validated node ID.
- `o_trigger_enable`  out  1: enables the trigger input path.
- `o_cfg_valid`  out  1: configuration loaded and validated.
- `o_cfg_busy`  out  1: load in progress (drives LED7).
- `o_cfg_error`  out  1: all attempts failed.
- `o_retry_cnt`  out  2: retries consumed in the current load.

## Operation
- Page layout:
  - b0: node_id.
  - b1: magic.
  - b2: flags; bit0 = force trigger enable.
  - b3–b6: reserved.
  - b7: checksum = b0^b1^…^b6.
- Page passes when b1 == `CFG_MAGIC` and b7 equals the XOR of b0–b6.
- On pass, `o_trigger_enable` = (b0 == `RX_ID_1`) | (b0 == `RX_ID_2`) | b2[0].
- FSM states:
  - INIT_WAIT: count from 0 to `WAIT_CNT`-1, then go to REQ.
  - REQ: while `i_eep_busy` is high, stay. When it is low, assert `o_eep_start` for one cycle, clear the timeout counter, go to WAIT_DONE.
  - WAIT_DONE: on `i_eep_done`, capture b0–b7 into internal registers and go to CHECK. Otherwise, if the timeout counter reaches `TIMEOUT_CNT`-1, take the RETRY path. Done wins over timeout when both occur in the same cycle.
  - CHECK: on pass, load the outputs, set `o_cfg_valid`=1 and `o_cfg_error`=0, go to RUN. On fail, take the RETRY path.
  - RETRY path: if `o_retry_cnt` < `MAX_RETRY`, increment it and go to REQ. Otherwise go to FAIL.
  - FAIL: `o_cfg_error`=1; `o_cfg_valid`, `o_trigger_enable` and `o_node_id` are 0.
  - RUN and FAIL: `i_reload` clears `o_retry_cnt`, `o_cfg_valid`, `o_cfg_error` and `o_trigger_enable`, then goes to REQ. The settle wait is skipped.
- `i_reload` is ignored in INIT_WAIT, REQ, WAIT_DONE and CHECK.
- `o_cfg_busy` = 1 in INIT_WAIT, REQ, WAIT_DONE and CHECK.
- `o_node_id` holds its last valid value during a reload until the next pass or FAIL.

## Timing
- Reset (`reset_n` low at a clock edge):
  - State goes to INIT_WAIT and all counters clear.
  - `o_eep_start`, `o_node_id`, `o_trigger_enable`, `o_cfg_valid`, `o_cfg_error` and `o_retry_cnt` are 0.
  - `o_cfg_busy` is 1.
  - Reset overrides any state, including an in-flight read. A late `i_eep_done` arriving in INIT_WAIT is ignored.
- All outputs are registered.
- First `o_eep_start` rises `WAIT_CNT`+1 cycles after reset release, provided busy is low.
- `o_eep_start` is high for exactly one cycle per attempt.
- `i_eep_done` coincident with the `o_eep_start` cycle is ignored as stale.
- Done-to-output latency:
  - `i_eep_done` is seen at edge t.
  - CHECK runs at t+1.
  - `o_cfg_valid`, `o_node_id` and `o_trigger_enable` update at edge t+2.
- Timeout: next `o_eep_start` follows no earlier than `TIMEOUT_CNT`+1 cycles after the previous one.
- Maximum attempts per load: `MAX_RETRY`+1.
- `o_retry_cnt` saturates at `MAX_RETRY`.

## Test plan
Bench parameters: `WAIT_CNT`=16, `TIMEOUT_CNT`=64, `MAX_RETRY`=2.

- Valid page b0=2, b1=A5, b2=0, b7=A7 → one start pulse at cycle 17 after reset. Two cycles after done: `o_cfg_valid`=1, `o_node_id`=2, `o_trigger_enable`=1, `o_cfg_busy`=0.
- b0=5 with b2=0 → valid=1, trigger=0. Reload with b0=5, b2=1 → trigger=1.
- Checksum always wrong → exactly 3 start pulses, `o_retry_cnt`=2, then `o_cfg_error`=1, `o_cfg_valid`=0.
- `i_eep_done` never asserted → start pulses spaced ≥65 cycles apart, 3 in total, then error. Done and timeout in the same cycle → CHECK is taken, not RETRY.
- `i_eep_busy` held high for 40 cycles in REQ → no start pulse until one cycle after busy falls.
- `i_reload` in RUN → valid and trigger drop on the next edge; new start without the 16-cycle wait.
- `reset_n` low during WAIT_DONE → all outputs per the reset list; a late done is ignored; the sequence restarts from INIT_WAIT.

Source files
------------

// File: rtl/eeprom_cfg_loader_if.sv
// Handshake and page-data bundle between the config loader and the I2C EEPROM reader.
// Latency: none, this is wiring only.
// Backpressure: the reader holds i_eep_busy high; the loader waits before it pulses o_eep_start.
// Ports (loader view): o_eep_start/o_eep_mode/o_eep_dev_addr/o_eep_page_addr out,
//   i_eep_busy/i_eep_done/i_page_b0..i_page_b7 in.
interface eeprom_cfg_loader_if;
   logic       o_eep_start;
   logic       o_eep_mode;
   logic [6:0] o_eep_dev_addr;
   logic [7:0] o_eep_page_addr;
   logic       i_eep_busy;
   logic       i_eep_done;
   logic [7:0] i_page_b0;
   logic [7:0] i_page_b1;
   logic [7:0] i_page_b2;
   logic [7:0] i_page_b3;
   logic [7:0] i_page_b4;
   logic [7:0] i_page_b5;
   logic [7:0] i_page_b6;
   logic [7:0] i_page_b7;

   modport master (
      output o_eep_start, o_eep_mode, o_eep_dev_addr, o_eep_page_addr,
      input  i_eep_busy, i_eep_done,
      input  i_page_b0, i_page_b1, i_page_b2, i_page_b3,
      input  i_page_b4, i_page_b5, i_page_b6, i_page_b7
   );

   modport slave (
      input  o_eep_start, o_eep_mode, o_eep_dev_addr, o_eep_page_addr,
      output i_eep_busy, i_eep_done,
      output i_page_b0, i_page_b1, i_page_b2, i_page_b3,
      output i_page_b4, i_page_b5, i_page_b6, i_page_b7
   );
endinterface

// File: rtl/eeprom_cfg_loader.sv
// Boot-time config sequencer: settle delay, EEPROM page read with timeout and retries, magic/XOR check.
// Latency: first start WAIT_CNT+1 cycles after reset; results publish 2 cycles after the done pulse.
// Backpressure: no start is issued while i_eep_busy is high; i_reload is honoured only in RUN/FAIL.
// Ports: clk, reset_n (sync, active-low), i_reload; eep (master modport) to the EEPROM reader;
//   o_node_id, o_trigger_enable, o_cfg_valid, o_cfg_busy, o_cfg_error, o_retry_cnt to the app top.
module eeprom_cfg_loader #(
   parameter int unsigned WAIT_CNT    = 10000000,
   parameter int unsigned TIMEOUT_CNT = 2000000,
   parameter int unsigned MAX_RETRY   = 3,
   parameter logic [6:0]  DEV_ADDR    = 7'h50,
   parameter logic [7:0]  PAGE_ADDR   = 8'h00,
   parameter logic [7:0]  RX_ID_1     = 8'd2,
   parameter logic [7:0]  RX_ID_2     = 8'd3,
   parameter logic [7:0]  CFG_MAGIC   = 8'hA5
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                i_reload,
   eeprom_cfg_loader_if.master eep,
   output logic [7:0]          o_node_id,
   output logic                o_trigger_enable,
   output logic                o_cfg_valid,
   output logic                o_cfg_busy,
   output logic                o_cfg_error,
   output logic [1:0]          o_retry_cnt
);

   localparam int WAIT_W = (WAIT_CNT > 1) ? $clog2(WAIT_CNT) : 1;
   localparam int TO_W   = (TIMEOUT_CNT > 1) ? $clog2(TIMEOUT_CNT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CNT - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CNT - 1);

   typedef enum logic [2:0] {
      S_INIT_WAIT,
      S_REQ,
      S_WAIT_DONE,
      S_CHECK,
      S_RUN,
      S_FAIL
   } state_t;

   state_t              r_state;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [TO_W-1:0]     r_to_cnt;
   logic [7:0][7:0]     r_page;
   // One-cycle result stage between CHECK and the published outputs.
   logic                r_chk_pass;
   logic                r_chk_trig;
   logic [7:0]          r_chk_id;

   state_t              w_state;
   logic [WAIT_W-1:0]   w_wait_cnt;
   logic [TO_W-1:0]     w_to_cnt;
   logic [1:0]          w_retry;
   logic                w_start;
   logic                w_cap;
   logic                w_retry_path;
   logic                w_reload;
   logic                w_busy;
   logic                w_fail_entry;
   logic                w_pass;
   logic                w_trig;

   assign eep.o_eep_mode      = 1'b0;
   assign eep.o_eep_dev_addr  = DEV_ADDR;
   assign eep.o_eep_page_addr = PAGE_ADDR;

   assign w_pass = (r_page[1] == CFG_MAGIC) &&
                   (r_page[7] == (r_page[0] ^ r_page[1] ^ r_page[2] ^ r_page[3] ^
                                  r_page[4] ^ r_page[5] ^ r_page[6]));
   assign w_trig = (r_page[0] == RX_ID_1) | (r_page[0] == RX_ID_2) | r_page[2][0];

   always_comb begin
      w_state      = r_state;
      w_wait_cnt   = r_wait_cnt;
      w_to_cnt     = r_to_cnt;
      w_retry      = o_retry_cnt;
      w_start      = 1'b0;
      w_cap        = 1'b0;
      w_retry_path = 1'b0;
      w_reload     = 1'b0;
      case (r_state)
         S_INIT_WAIT: begin
            if (r_wait_cnt == WAIT_LAST) w_state = S_REQ;
            else                         w_wait_cnt = r_wait_cnt + 1'b1;
         end
         S_REQ: begin
            if (!eep.i_eep_busy) begin
               w_start  = 1'b1;
               w_to_cnt = '0;
               w_state  = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            // A done overlapping our own start pulse belongs to an earlier request.
            if (eep.i_eep_done && !eep.o_eep_start) begin
               w_cap   = 1'b1;
               w_state = S_CHECK;
            end else if (r_to_cnt == TO_LAST) begin
               w_retry_path = 1'b1;
            end else begin
               w_to_cnt = r_to_cnt + 1'b1;
            end
         end
         S_CHECK: begin
            if (w_pass) w_state = S_RUN;
            else        w_retry_path = 1'b1;
         end
         S_RUN, S_FAIL: begin
            if (i_reload) begin
               w_reload = 1'b1;
               w_retry  = '0;
               w_state  = S_REQ;
            end
         end
         default: w_state = S_INIT_WAIT;
      endcase
      if (w_retry_path) begin
         if ({30'd0, o_retry_cnt} < 32'(MAX_RETRY)) begin
            w_retry = o_retry_cnt + 2'd1;
            w_state = S_REQ;
         end else begin
            w_state = S_FAIL;
         end
      end
   end

   assign w_busy       = (w_state == S_INIT_WAIT) || (w_state == S_REQ) ||
                         (w_state == S_WAIT_DONE) || (w_state == S_CHECK);
   assign w_fail_entry = (w_state == S_FAIL) && (r_state != S_FAIL);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state          <= S_INIT_WAIT;
         r_wait_cnt       <= '0;
         r_to_cnt         <= '0;
         r_page           <= '0;
         r_chk_pass       <= 1'b0;
         r_chk_trig       <= 1'b0;
         r_chk_id         <= '0;
         eep.o_eep_start  <= 1'b0;
         o_node_id        <= '0;
         o_trigger_enable <= 1'b0;
         o_cfg_valid      <= 1'b0;
         o_cfg_busy       <= 1'b1;
         o_cfg_error      <= 1'b0;
         o_retry_cnt      <= '0;
      end else begin
         r_state         <= w_state;
         r_wait_cnt      <= w_wait_cnt;
         r_to_cnt        <= w_to_cnt;
         o_retry_cnt     <= w_retry;
         eep.o_eep_start <= w_start;
         o_cfg_busy      <= w_busy;
         if (w_cap) begin
            r_page <= {eep.i_page_b7, eep.i_page_b6, eep.i_page_b5, eep.i_page_b4,
                       eep.i_page_b3, eep.i_page_b2, eep.i_page_b1, eep.i_page_b0};
         end
         r_chk_pass <= (r_state == S_CHECK) && w_pass;
         r_chk_trig <= w_trig;
         r_chk_id   <= r_page[0];
         // Node ID is left alone on reload so the app keeps its last good ID until the next verdict.
         if (w_reload) begin
            o_cfg_valid      <= 1'b0;
            o_cfg_error      <= 1'b0;
            o_trigger_enable <= 1'b0;
         end else if (w_fail_entry) begin
            o_cfg_error      <= 1'b1;
            o_cfg_valid      <= 1'b0;
            o_trigger_enable <= 1'b0;
            o_node_id        <= '0;
         end else if (r_chk_pass) begin
            o_cfg_valid      <= 1'b1;
            o_cfg_error      <= 1'b0;
            o_node_id        <= r_chk_id;
            o_trigger_enable <= r_chk_trig;
         end
      end
   end

endmodule

// File: tb/tb_eeprom_cfg_loader.sv
// Directed bench for eeprom_cfg_loader with a short settle/timeout and two retries.
// Inputs change 1 time unit after the rising edge; outputs are sampled at that same point.
module tb_eeprom_cfg_loader;
   localparam int WAIT_CNT    = 16;
   localparam int TIMEOUT_CNT = 64;
   localparam int MAX_RETRY   = 2;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       i_reload = 1'b0;
   logic [7:0] o_node_id;
   logic       o_trigger_enable;
   logic       o_cfg_valid;
   logic       o_cfg_busy;
   logic       o_cfg_error;
   logic [1:0] o_retry_cnt;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int n_start = 0;
   int last_start = 0;

   eeprom_cfg_loader_if eep();

   eeprom_cfg_loader #(
      .WAIT_CNT(WAIT_CNT), .TIMEOUT_CNT(TIMEOUT_CNT), .MAX_RETRY(MAX_RETRY),
      .DEV_ADDR(7'h50), .PAGE_ADDR(8'h00), .RX_ID_1(8'd2), .RX_ID_2(8'd3), .CFG_MAGIC(8'hA5)
   ) dut (
      .clk(clk), .reset_n(reset_n), .i_reload(i_reload), .eep(eep),
      .o_node_id(o_node_id), .o_trigger_enable(o_trigger_enable), .o_cfg_valid(o_cfg_valid),
      .o_cfg_busy(o_cfg_busy), .o_cfg_error(o_cfg_error), .o_retry_cnt(o_retry_cnt)
   );

   always #25 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      if (eep.o_eep_start === 1'b1) begin
         n_start++;
         last_start = cyc;
      end
   endtask

   task automatic set_page(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] b3, input logic [7:0] b7);
      eep.i_page_b0 = b0; eep.i_page_b1 = b1; eep.i_page_b2 = b2; eep.i_page_b3 = b3;
      eep.i_page_b4 = 8'h00; eep.i_page_b5 = 8'h00; eep.i_page_b6 = 8'h00; eep.i_page_b7 = b7;
   endtask

   task automatic pulse_done();
      eep.i_eep_done = 1'b1;
      tick();
      eep.i_eep_done = 1'b0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      cyc = 0;
      n_start = 0;
   endtask

   // Bounded wait for the next start pulse; an expired bound is a failure.
   task automatic wait_start(input int max_cyc);
      int seen;
      seen = 0;
      for (int i = 0; i < max_cyc && seen == 0; i++) begin
         tick();
         if (eep.o_eep_start === 1'b1) seen = 1;
      end
      n_tests++;
      if (seen == 0) begin
         n_fail++;
         $display("FAIL wait_start: no start pulse within %0d cycles (need one)", max_cyc);
      end
   endtask

   task automatic do_reload();
      i_reload = 1'b1;
      tick();
      i_reload = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (eep.o_eep_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", eep.o_eep_start); end
      n_tests++; if (o_node_id !== 8'h00) begin n_fail++; $display("FAIL reset_node_id: got %h want 00", o_node_id); end
      n_tests++; if (o_trigger_enable !== 1'b0) begin n_fail++; $display("FAIL reset_trig: got %b want 0", o_trigger_enable); end
      n_tests++; if (o_cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_cfg_valid); end
      n_tests++; if (o_cfg_error !== 1'b0) begin n_fail++; $display("FAIL reset_error: got %b want 0", o_cfg_error); end
      n_tests++; if (o_retry_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_retry: got %0d want 0", o_retry_cnt); end
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", o_cfg_busy); end
      n_tests++; if (eep.o_eep_mode !== 1'b0) begin n_fail++; $display("FAIL eep_mode: got %b want 0", eep.o_eep_mode); end
      n_tests++; if (eep.o_eep_dev_addr !== 7'h50) begin n_fail++; $display("FAIL dev_addr: got %h want 50", eep.o_eep_dev_addr); end
      n_tests++; if (eep.o_eep_page_addr !== 8'h00) begin n_fail++; $display("FAIL page_addr: got %h want 00", eep.o_eep_page_addr); end
   endtask

   task automatic test_valid_page();
      do_reset();
      wait_start(40);
      n_tests++; if (last_start != 17) begin n_fail++; $display("FAIL first_start_cycle: got %0d want 17", last_start); end
      // Done during the start cycle carries a bad page and must be ignored.
      set_page(8'h02, 8'hA5, 8'h00, 8'h00, 8'h00);
      pulse_done();
      n_tests++; if (eep.o_eep_start !== 1'b0) begin n_fail++; $display("FAIL start_width: got %b want 0", eep.o_eep_start); end
      set_page(8'h02, 8'hA5, 8'h00, 8'h00, 8'hA7);
      pulse_done();
      tick();
      n_tests++; if (o_cfg_valid !== 1'b0) begin n_fail++; $display("FAIL valid_early: got %b want 0 one cycle after done", o_cfg_valid); end
      tick();
      n_tests++; if (o_cfg_valid !== 1'b1) begin n_fail++; $display("FAIL valid_pass: got %b want 1", o_cfg_valid); end
      n_tests++; if (o_node_id !== 8'h02) begin n_fail++; $display("FAIL node_id_pass: got %h want 02", o_node_id); end
      n_tests++; if (o_trigger_enable !== 1'b1) begin n_fail++; $display("FAIL trig_rx1: got %b want 1", o_trigger_enable); end
      n_tests++; if (o_cfg_busy !== 1'b0) begin n_fail++; $display("FAIL busy_run: got %b want 0", o_cfg_busy); end
      repeat (80) tick();
      n_tests++; if (n_start != 1) begin n_fail++; $display("FAIL single_start: got %0d starts want 1", n_start); end
   endtask

   task automatic test_trigger_reload();
      int c0;
      do_reset();
      wait_start(40);
      tick();
      set_page(8'h05, 8'hA5, 8'h00, 8'h00, 8'hA0);
      pulse_done();
      tick();
      tick();
      n_tests++; if (o_cfg_valid !== 1'b1) begin n_fail++; $display("FAIL valid_id5: got %b want 1", o_cfg_valid); end
      n_tests++; if (o_trigger_enable !== 1'b0) begin n_fail++; $display("FAIL trig_id5: got %b want 0", o_trigger_enable); end
      n_tests++; if (o_node_id !== 8'h05) begin n_fail++; $display("FAIL node_id5: got %h want 05", o_node_id); end
      do_reload();
      c0 = cyc;
      n_tests++; if (o_cfg_valid !== 1'b0) begin n_fail++; $display("FAIL reload_valid: got %b want 0", o_cfg_valid); end
      n_tests++; if (o_trigger_enable !== 1'b0) begin n_fail++; $display("FAIL reload_trig: got %b want 0", o_trigger_enable); end
      n_tests++; if (o_node_id !== 8'h05) begin n_fail++; $display("FAIL reload_hold_id: got %h want 05", o_node_id); end
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("FAIL reload_busy: got %b want 1", o_cfg_busy); end
      wait_start(40);
      n_tests++; if (last_start - c0 != 1) begin n_fail++; $display("FAIL reload_start_delay: got %0d want 1", last_start - c0); end
      tick();
      set_page(8'h05, 8'hA5, 8'h01, 8'h10, 8'hB1);
      pulse_done();
      tick();
      tick();
      n_tests++; if (o_trigger_enable !== 1'b1) begin n_fail++; $display("FAIL trig_force: got %b want 1", o_trigger_enable); end
      n_tests++; if (o_cfg_valid !== 1'b1) begin n_fail++; $display("FAIL valid_force: got %b want 1", o_cfg_valid); end
   endtask

   task automatic test_bad_checksum();
      n_start = 0;
      do_reload();
      for (int a = 0; a < 3; a++) begin
         wait_start(100);
         tick();
         set_page(8'h05, 8'hA5, 8'h01, 8'h10, 8'h00);
         pulse_done();
         if (a == 0) begin
            tick();
            n_tests++; if (o_retry_cnt !== 2'd1) begin n_fail++; $display("FAIL retry_after_first: got %0d want 1", o_retry_cnt); end
            n_tests++; if (o_node_id !== 8'h05) begin n_fail++; $display("FAIL id_held_retry: got %h want 05", o_node_id); end
         end
      end
      repeat (5) tick();
      n_tests++; if (o_cfg_error !== 1'b1) begin n_fail++; $display("FAIL csum_error: got %b want 1", o_cfg_error); end
      n_tests++; if (o_cfg_valid !== 1'b0) begin n_fail++; $display("FAIL csum_valid: got %b want 0", o_cfg_valid); end
      n_tests++; if (o_node_id !== 8'h00) begin n_fail++; $display("FAIL csum_node_id: got %h want 00", o_node_id); end
      n_tests++; if (o_retry_cnt !== 2'd2) begin n_fail++; $display("FAIL csum_retry: got %0d want 2", o_retry_cnt); end
      n_tests++; if (o_cfg_busy !== 1'b0) begin n_fail++; $display("FAIL csum_busy: got %b want 0", o_cfg_busy); end
      repeat (150) tick();
      n_tests++; if (n_start != 3) begin n_fail++; $display("FAIL csum_starts: got %0d want 3", n_start); end
   endtask

   task automatic test_timeout();
      int s0, s1, s2;
      n_start = 0;
      do_reload();
      n_tests++; if (o_cfg_error !== 1'b0) begin n_fail++; $display("FAIL reload_fail_error: got %b want 0", o_cfg_error); end
      wait_start(20);
      s0 = last_start;
      wait_start(200);
      s1 = last_start;
      wait_start(200);
      s2 = last_start;
      n_tests++; if (s1 - s0 < 65) begin n_fail++; $display("FAIL to_gap1: got %0d want >=65", s1 - s0); end
      n_tests++; if (s2 - s1 < 65) begin n_fail++; $display("FAIL to_gap2: got %0d want >=65", s2 - s1); end
      repeat (80) tick();
      n_tests++; if (o_cfg_error !== 1'b1) begin n_fail++; $display("FAIL to_error: got %b want 1", o_cfg_error); end
      n_tests++; if (n_start != 3) begin n_fail++; $display("FAIL to_starts: got %0d want 3", n_start); end
   endtask

   task automatic test_done_timeout_race();
      n_start = 0;
      do_reload();
      wait_start(20);
      repeat (TIMEOUT_CNT - 1) tick();
      set_page(8'h03, 8'hA5, 8'h00, 8'h00, 8'hA6);
      pulse_done();
      tick();
      n_tests++; if (eep.o_eep_start !== 1'b0) begin n_fail++; $display("FAIL race_start: got %b want 0", eep.o_eep_start); end
      n_tests++; if (o_retry_cnt !== 2'd0) begin n_fail++; $display("FAIL race_retry: got %0d want 0", o_retry_cnt); end
      tick();
      n_tests++; if (o_cfg_valid !== 1'b1) begin n_fail++; $display("FAIL race_valid: got %b want 1", o_cfg_valid); end
      n_tests++; if (o_node_id !== 8'h03) begin n_fail++; $display("FAIL race_id: got %h want 03", o_node_id); end
      n_tests++; if (o_trigger_enable !== 1'b1) begin n_fail++; $display("FAIL trig_rx2: got %b want 1", o_trigger_enable); end
   endtask

   task automatic test_reset_midflight();
      n_start = 0;
      do_reload();
      wait_start(20);
      repeat (3) tick();
      reset_n = 1'b0;
      set_page(8'h02, 8'hA5, 8'h00, 8'h00, 8'hA7);
      eep.i_eep_done = 1'b1;
      tick();
      n_tests++; if (o_node_id !== 8'h00) begin n_fail++; $display("FAIL mid_node_id: got %h want 00", o_node_id); end
      n_tests++; if (o_cfg_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", o_cfg_busy); end
      n_tests++; if (o_trigger_enable !== 1'b0) begin n_fail++; $display("FAIL mid_trig: got %b want 0", o_trigger_enable); end
      n_tests++; if (o_retry_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_retry: got %0d want 0", o_retry_cnt); end
      n_tests++; if (eep.o_eep_start !== 1'b0) begin n_fail++; $display("FAIL mid_start: got %b want 0", eep.o_eep_start); end
      reset_n = 1'b1;
      cyc = 0;
      n_start = 0;
      tick();
      eep.i_eep_done = 1'b0;
      wait_start(40);
      n_tests++; if (last_start != 17) begin n_fail++; $display("FAIL mid_restart_cycle: got %0d want 17", last_start); end
      n_tests++; if (o_cfg_valid !== 1'b0) begin n_fail++; $display("FAIL late_done_valid: got %b want 0", o_cfg_valid); end
   endtask

   task automatic test_busy();
      eep.i_eep_busy = 1'b1;
      do_reset();
      repeat (WAIT_CNT + 40) tick();
      n_tests++; if (n_start != 0) begin n_fail++; $display("FAIL busy_hold: got %0d starts want 0", n_start); end
      eep.i_eep_busy = 1'b0;
      tick();
      n_tests++; if (eep.o_eep_start !== 1'b1) begin n_fail++; $display("FAIL busy_release: got %b want 1", eep.o_eep_start); end
   endtask

   initial begin
      eep.i_eep_busy = 1'b0;
      eep.i_eep_done = 1'b0;
      set_page(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
      test_reset();
      test_valid_page();
      test_trigger_reload();
      test_bad_checksum();
      test_timeout();
      test_done_timeout_race();
      test_reset_midflight();
      test_busy();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
